// File: rtl/login_pkg.sv
// Shared types and constants for the keypad login sequencer.
// Holds the FSM state encoding and the per-state output flags.
package login_pkg;

   localparam int DIGITS_PER_FIELD = 4;
   localparam int ENTRY_LEN        = 8;
   localparam int FIELD_W          = 16;

   typedef enum logic [2:0] {
      ST_CLEAR   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_CHECK   = 3'd2,
      ST_GRANT   = 3'd3,
      ST_DENY    = 3'd4,
      ST_LOCKOUT = 3'd5
   } state_t;

   typedef struct packed {
      logic clear_entry;
      logic granted;
      logic denied;
      logic locked;
      logic busy;
   } flags_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Moore output flags for a state; registered together with the state itself.
   function automatic flags_t state_flags(input state_t s);
      flags_t f;
      f = '0;
      case (s)
         ST_CLEAR:   begin f.clear_entry = 1'b1; f.busy = 1'b1; end
         ST_IDLE:    ;
         ST_CHECK:   f.busy = 1'b1;
         ST_GRANT:   begin f.clear_entry = 1'b1; f.granted = 1'b1; f.busy = 1'b1; end
         ST_DENY:    begin f.clear_entry = 1'b1; f.denied  = 1'b1; f.busy = 1'b1; end
         ST_LOCKOUT: begin f.clear_entry = 1'b1; f.locked  = 1'b1; f.busy = 1'b1; end
         default:    begin f.clear_entry = 1'b1; f.busy = 1'b1; end
      endcase
      return f;
   endfunction

endpackage

// File: rtl/login_sequencer_if.sv
// Keypad-decoder and display/unlock signals of the login sequencer.
// slave is the sequencer side, master the decoder/display side.
interface login_sequencer_if #(
   parameter int UW = 2,
   parameter int FW = 2
);
   logic [3:0]    inputCount;
   logic [15:0]   userNameIn;
   logic [15:0]   passwordIn;
   logic          cancel;
   logic          clearEntry;
   logic          accessGranted;
   logic          accessDenied;
   logic          lockedOut;
   logic [UW-1:0] matchedUser;
   logic [FW-1:0] attemptsLeft;
   logic          entryPhase;
   logic          busy;

   modport slave (
      input  inputCount, userNameIn, passwordIn, cancel,
      output clearEntry, accessGranted, accessDenied, lockedOut,
             matchedUser, attemptsLeft, entryPhase, busy
   );

   modport master (
      output inputCount, userNameIn, passwordIn, cancel,
      input  clearEntry, accessGranted, accessDenied, lockedOut,
             matchedUser, attemptsLeft, entryPhase, busy
   );
endinterface

// File: rtl/hold_timer.sv
// Loadable down-counter that parks at zero; used for grant/deny/lockout hold times.
module hold_timer #(
   parameter int WIDTH = 15
) (
   input  logic             clk1KHz,
   input  logic             resetN,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // NOTE: sequential state is written only with non-blocking assignments so every
   // register samples pre-edge values, matching the hardware.
   always_ff @(posedge clk1KHz or negedge resetN) begin
      if (!resetN) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/login_sequencer.sv
// Keypad login flow: snapshot an 8-digit entry, scan the credential table one
// entry per cycle, show grant/deny for a fixed time and lock out after repeated failures.
module login_sequencer
   import login_pkg::*;
#(
   parameter int NUM_USERS  = 4,
   parameter int MAX_FAILS  = 3,
   parameter int HOLD_TICKS = 2000,
   parameter int LOCK_TICKS = 30000,
   parameter logic [FIELD_W*NUM_USERS-1:0] USER_TABLE = 64'h4321_9753_2468_1234,
   parameter logic [FIELD_W*NUM_USERS-1:0] PASS_TABLE = 64'h0007_5555_1357_8642
) (
   input logic             clk1KHz,
   input logic             resetN,
   login_sequencer_if.slave bus
);

   localparam int UW     = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
   localparam int FW     = $clog2(MAX_FAILS + 1);
   localparam int TW_RAW = $clog2(max_int(HOLD_TICKS, LOCK_TICKS));
   localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_TICKS - 1);
   localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_TICKS - 1);
   localparam logic [UW-1:0] LAST_IDX  = UW'(NUM_USERS - 1);
   localparam logic [FW-1:0] FAILS_MAX = FW'(MAX_FAILS);

   state_t             state;
   flags_t             flags;
   logic [UW-1:0]      idx;
   logic [UW-1:0]      matched_user;
   logic [FW-1:0]      fail_count;
   logic [FIELD_W-1:0] user_snap;
   logic [FIELD_W-1:0] pass_snap;

   logic               entry_match;
   logic               timer_load;
   logic [TW-1:0]      timer_value;
   logic               timer_zero;

   assign entry_match =
      (user_snap == USER_TABLE[FIELD_W*int'(idx) +: FIELD_W]) &&
      (pass_snap == PASS_TABLE[FIELD_W*int'(idx) +: FIELD_W]);

   // The timer loads only on the edge that enters GRANT, DENY or LOCKOUT.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      timer_load  = 1'b0;
      timer_value = HOLD_LOAD;
      case (state)
         ST_CHECK: begin
            if (entry_match || idx == LAST_IDX) timer_load = 1'b1;
         end
         ST_DENY: begin
            if (timer_zero && fail_count == FAILS_MAX) begin
               timer_load  = 1'b1;
               timer_value = LOCK_LOAD;
            end
         end
         default: ;
      endcase
   end

   hold_timer #(.WIDTH(TW)) u_hold_timer (
      .clk1KHz (clk1KHz),
      .resetN  (resetN),
      .load    (timer_load),
      .value   (timer_value),
      .zero    (timer_zero)
   );

   always_ff @(posedge clk1KHz or negedge resetN) begin
      if (!resetN) begin
         state        <= ST_CLEAR;
         flags        <= state_flags(ST_CLEAR);
         idx          <= '0;
         fail_count   <= '0;
         matched_user <= '0;
         user_snap    <= '0;
         pass_snap    <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               state <= ST_IDLE;
               flags <= state_flags(ST_IDLE);
            end
            ST_IDLE: begin
               // cancel takes priority over a completed entry
               if (bus.cancel) begin
                  state <= ST_CLEAR;
                  flags <= state_flags(ST_CLEAR);
               end else if (bus.inputCount >= 4'(ENTRY_LEN)) begin
                  state     <= ST_CHECK;
                  flags     <= state_flags(ST_CHECK);
                  user_snap <= bus.userNameIn;
                  pass_snap <= bus.passwordIn;
                  idx       <= '0;
               end
            end
            ST_CHECK: begin
               if (entry_match) begin
                  state        <= ST_GRANT;
                  flags        <= state_flags(ST_GRANT);
                  matched_user <= idx;
                  fail_count   <= '0;
               end else if (idx == LAST_IDX) begin
                  state <= ST_DENY;
                  flags <= state_flags(ST_DENY);
                  if (fail_count != FAILS_MAX) fail_count <= fail_count + 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_GRANT: begin
               if (timer_zero) begin
                  state <= ST_IDLE;
                  flags <= state_flags(ST_IDLE);
               end
            end
            ST_DENY: begin
               if (timer_zero) begin
                  if (fail_count == FAILS_MAX) begin
                     state <= ST_LOCKOUT;
                     flags <= state_flags(ST_LOCKOUT);
                  end else begin
                     state <= ST_IDLE;
                     flags <= state_flags(ST_IDLE);
                  end
               end
            end
            ST_LOCKOUT: begin
               if (timer_zero) begin
                  state      <= ST_IDLE;
                  flags      <= state_flags(ST_IDLE);
                  fail_count <= '0;
               end
            end
            default: begin
               state <= ST_CLEAR;
               flags <= state_flags(ST_CLEAR);
            end
         endcase
      end
   end

   assign bus.clearEntry    = flags.clear_entry;
   assign bus.accessGranted = flags.granted;
   assign bus.accessDenied  = flags.denied;
   assign bus.lockedOut     = flags.locked;
   assign bus.busy          = flags.busy;
   assign bus.matchedUser   = matched_user;
   assign bus.attemptsLeft  = flags.locked ? '0 : (FAILS_MAX - fail_count);
   assign bus.entryPhase    = (bus.inputCount >= 4'(DIGITS_PER_FIELD));

endmodule

// File: tb/tb_login_sequencer.sv
// Directed bench for login_sequencer: grant, deny, lockout, cancel and reset cases
// against a hand-written credential table.
module tb_login_sequencer;

   localparam logic [63:0] USER_T = 64'h4321_9753_2468_1234;
   localparam logic [63:0] PASS_T = 64'h0007_5555_1357_8642;

   logic clk1KHz = 1'b0;
   logic resetN  = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk1KHz = ~clk1KHz;

   login_sequencer_if #(.UW(2), .FW(2)) bus ();

   login_sequencer #(
      .NUM_USERS  (4),
      .MAX_FAILS  (3),
      .HOLD_TICKS (2000),
      .LOCK_TICKS (30000),
      .USER_TABLE (USER_T),
      .PASS_TABLE (PASS_T)
   ) dut (
      .clk1KHz (clk1KHz),
      .resetN  (resetN),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk1KHz);
   endtask

   // Present a complete 8-digit entry for one edge, then drop it as the decoder would.
   task automatic login(input logic [15:0] u, input logic [15:0] p);
      bus.userNameIn = u;
      bus.passwordIn = p;
      bus.inputCount = 4'd8;
      tick();
      bus.inputCount = 4'd0;
      bus.userNameIn = 16'h0000;
      bus.passwordIn = 16'h0000;
   endtask

   task automatic count_check(output int n);
      n = 0;
      while (bus.busy && !bus.accessGranted && !bus.accessDenied && !bus.lockedOut && n < 16) begin
         n++;
         tick();
      end
   endtask

   function automatic logic pick(input int sel);
      case (sel)
         0:       return bus.accessGranted;
         1:       return bus.accessDenied;
         default: return bus.lockedOut;
      endcase
   endfunction

   task automatic hold_len(input int sel, output int n, output int clr);
      n   = 0;
      clr = 0;
      while (pick(sel) && n < 40000) begin
         if (bus.clearEntry) clr++;
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      int clr;
      bus.inputCount = 4'd0;
      bus.userNameIn = 16'h0000;
      bus.passwordIn = 16'h0000;
      bus.cancel     = 1'b0;

      repeat (3) tick();
      check("rst_clear",   32'(bus.clearEntry),    32'd1);
      check("rst_busy",    32'(bus.busy),          32'd1);
      check("rst_granted", 32'(bus.accessGranted), 32'd0);
      check("rst_denied",  32'(bus.accessDenied),  32'd0);
      check("rst_locked",  32'(bus.lockedOut),     32'd0);
      check("rst_attempts",32'(bus.attemptsLeft),  32'd3);
      check("rst_matched", 32'(bus.matchedUser),   32'd0);

      resetN = 1'b1;
      #1;
      check("clear_pulse", 32'(bus.clearEntry), 32'd1);
      tick();
      check("idle_clear",    32'(bus.clearEntry),   32'd0);
      check("idle_busy",     32'(bus.busy),         32'd0);
      check("idle_attempts", 32'(bus.attemptsLeft), 32'd3);
      check("idle_phase",    32'(bus.entryPhase),   32'd0);

      // Entry 2 matches on the third CHECK cycle.
      login(16'h9753, 16'h5555);
      count_check(n);
      check("g2_check_cycles", 32'(n), 32'd3);
      check("g2_granted", 32'(bus.accessGranted), 32'd1);
      check("g2_matched", 32'(bus.matchedUser),   32'd2);
      hold_len(0, n, clr);
      check("g2_hold", 32'(n),   32'd2000);
      check("g2_clr",  32'(clr), 32'd2000);
      check("g2_idle_busy",     32'(bus.busy),         32'd0);
      check("g2_idle_attempts", 32'(bus.attemptsLeft), 32'd3);

      // Username of entry 0 right, password wrong: full scan then DENY.
      login(16'h1234, 16'h8643);
      count_check(n);
      check("d0_check_cycles", 32'(n), 32'd4);
      check("d0_denied",   32'(bus.accessDenied), 32'd1);
      check("d0_attempts", 32'(bus.attemptsLeft), 32'd2);
      hold_len(1, n, clr);
      check("d0_hold", 32'(n),   32'd2000);
      check("d0_clr",  32'(clr), 32'd2000);
      check("d0_idle_busy", 32'(bus.busy), 32'd0);

      // Cancel part-way through the password.
      bus.inputCount = 4'd5;
      #1;
      check("phase_pw", 32'(bus.entryPhase), 32'd1);
      bus.cancel = 1'b1;
      tick();
      check("cancel_clear", 32'(bus.clearEntry), 32'd1);
      check("cancel_busy",  32'(bus.busy),       32'd1);
      bus.cancel     = 1'b0;
      bus.inputCount = 4'd0;
      tick();
      check("cancel_idle_clear", 32'(bus.clearEntry),   32'd0);
      check("cancel_idle_busy",  32'(bus.busy),         32'd0);
      check("cancel_attempts",   32'(bus.attemptsLeft), 32'd2);

      // Cancel on the same edge as a valid complete entry.
      bus.userNameIn = 16'h9753;
      bus.passwordIn = 16'h5555;
      bus.inputCount = 4'd8;
      bus.cancel     = 1'b1;
      tick();
      check("cancel8_clear",   32'(bus.clearEntry),    32'd1);
      check("cancel8_granted", 32'(bus.accessGranted), 32'd0);
      bus.cancel     = 1'b0;
      bus.inputCount = 4'd0;
      bus.userNameIn = 16'h0000;
      bus.passwordIn = 16'h0000;
      tick();
      check("cancel8_idle_busy", 32'(bus.busy),         32'd0);
      check("cancel8_attempts",  32'(bus.attemptsLeft), 32'd2);

      // Grant after a failure restores the attempt budget.
      login(16'h2468, 16'h1357);
      count_check(n);
      check("g1_check_cycles", 32'(n), 32'd2);
      check("g1_granted",  32'(bus.accessGranted), 32'd1);
      check("g1_matched",  32'(bus.matchedUser),   32'd1);
      check("g1_attempts", 32'(bus.attemptsLeft),  32'd3);
      hold_len(0, n, clr);
      check("g1_hold", 32'(n), 32'd2000);

      // Three consecutive failures lead into lockout.
      for (int i = 0; i < 3; i++) begin
         login(16'h0000, 16'h0000);
         count_check(n);
         check($sformatf("lk_check_cycles_%0d", i), 32'(n), 32'd4);
         check($sformatf("lk_denied_%0d", i), 32'(bus.accessDenied), 32'd1);
         check($sformatf("lk_attempts_%0d", i), 32'(bus.attemptsLeft), 32'(2 - i));
         hold_len(1, n, clr);
         check($sformatf("lk_hold_%0d", i), 32'(n), 32'd2000);
         if (i < 2) check($sformatf("lk_idle_%0d", i), 32'(bus.busy), 32'd0);
      end
      check("lock_active",   32'(bus.lockedOut),    32'd1);
      check("lock_attempts", 32'(bus.attemptsLeft), 32'd0);
      hold_len(2, n, clr);
      check("lock_hold", 32'(n),   32'd30000);
      check("lock_clr",  32'(clr), 32'd30000);
      check("unlock_attempts", 32'(bus.attemptsLeft), 32'd3);
      check("unlock_busy",     32'(bus.busy),         32'd0);

      // Lock out again, then reset 100 cycles into the lockout.
      for (int i = 0; i < 3; i++) begin
         login(16'h0000, 16'h0000);
         count_check(n);
         hold_len(1, n, clr);
         check($sformatf("rl_hold_%0d", i), 32'(n), 32'd2000);
      end
      check("rl_locked", 32'(bus.lockedOut), 32'd1);
      repeat (99) tick();
      check("rl_still_locked", 32'(bus.lockedOut), 32'd1);
      resetN = 1'b0;
      #1;
      check("rl_locked_rst",   32'(bus.lockedOut),    32'd0);
      check("rl_clear_rst",    32'(bus.clearEntry),   32'd1);
      check("rl_busy_rst",     32'(bus.busy),         32'd1);
      check("rl_attempts_rst", 32'(bus.attemptsLeft), 32'd3);
      check("rl_matched_rst",  32'(bus.matchedUser),  32'd0);
      tick();
      resetN = 1'b1;
      tick();
      check("rl_idle_busy", 32'(bus.busy), 32'd0);
      login(16'h4321, 16'h0007);
      count_check(n);
      check("g3_check_cycles", 32'(n), 32'd4);
      check("g3_granted", 32'(bus.accessGranted), 32'd1);
      check("g3_matched", 32'(bus.matchedUser),   32'd3);
      hold_len(0, n, clr);
      check("g3_hold", 32'(n), 32'd2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
